// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: funct3 codes, bus widths and FSM state encoding.
package div_unit_pkg;

   localparam int REGBUS_W  = 32;
   localparam int REGADDR_W = 5;

   typedef logic [REGBUS_W-1:0]  reg_bus_t;
   typedef logic [REGADDR_W-1:0] reg_addr_t;

   localparam logic [2:0] INST_DIV  = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM  = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_CALC  = 2'd2,
      S_END   = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Signed ops divide magnitudes and fix the signs at the end.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN       = REGBUS_W,
   parameter int REG_ADDR_W = REGADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [XLEN-1:0]       dividend_i,
   input  logic [XLEN-1:0]       divisor_i,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [REG_ADDR_W-1:0] reg_waddr_i,
   output logic [XLEN-1:0]       result_o,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic [REG_ADDR_W-1:0] reg_waddr_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] ONE = XLEN'(1);

   function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
      return (~v) + ONE;
   endfunction

   function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v, input logic en);
      return (en && v[XLEN-1]) ? f_neg(v) : v;
   endfunction

   div_state_e            r_state, w_state_nx;
   logic [XLEN-1:0]       r_dvd, r_dsr, r_dmag, r_rem, r_quo;
   logic [2:0]            r_op;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic [CNT_W-1:0]      r_cnt;

   logic [XLEN-1:0]       r_result;
   logic                  r_ready, r_busy;
   logic [REG_ADDR_W-1:0] r_waddr_o;

   logic [XLEN-1:0]       w_result_nx;
   logic                  w_ready_nx, w_busy_nx;
   logic [REG_ADDR_W-1:0] w_waddr_nx;

   logic                  w_signed, w_is_rem;
   logic [XLEN:0]         w_shift, w_diff;
   logic [XLEN-1:0]       w_quo_fix, w_rem_fix, w_final;

   assign w_signed = (r_op == INST_DIV) || (r_op == INST_REM);
   assign w_is_rem = (r_op == INST_REM) || (r_op == INST_REMU);

   // One restoring step: shift the next dividend bit in, subtract if it fits.
   assign w_shift = {r_rem, r_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_dmag};

   assign w_quo_fix = (w_signed && (r_dvd[XLEN-1] ^ r_dsr[XLEN-1])) ? f_neg(r_quo) : r_quo;
   assign w_rem_fix = (w_signed && r_dvd[XLEN-1]) ? f_neg(r_rem) : r_rem;
   assign w_final   = w_is_rem ? w_rem_fix : w_quo_fix;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nx;
   end

   // Next-state logic; start_i low anywhere past IDLE aborts
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_nx = S_START;
         S_START: begin
            if (!start_i || r_dsr == '0) w_state_nx = S_IDLE;
            else                         w_state_nx = S_CALC;
         end
         S_CALC: begin
            if (!start_i)                  w_state_nx = S_IDLE;
            else if (r_cnt == CNT_W'(1))   w_state_nx = S_END;
         end
         S_END:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Output values for the next cycle
   always_comb begin
      w_result_nx = '0;
      w_ready_nx  = 1'b0;
      w_busy_nx   = 1'b0;
      w_waddr_nx  = '0;
      case (r_state)
         S_IDLE:  w_busy_nx = start_i;
         S_START: begin
            if (start_i) begin
               if (r_dsr == '0) begin
                  w_ready_nx  = 1'b1;
                  w_waddr_nx  = r_waddr;
                  w_result_nx = w_is_rem ? r_dvd : '1;
               end else begin
                  w_busy_nx = 1'b1;
               end
            end
         end
         S_CALC:  w_busy_nx = start_i;
         S_END: begin
            if (start_i) begin
               w_ready_nx  = 1'b1;
               w_waddr_nx  = r_waddr;
               w_result_nx = w_final;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result  <= '0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_waddr_o <= '0;
      end else begin
         r_result  <= w_result_nx;
         r_ready   <= w_ready_nx;
         r_busy    <= w_busy_nx;
         r_waddr_o <= w_waddr_nx;
      end
   end

   // Datapath; r_quo starts as the dividend magnitude and fills with quotient bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_dmag  <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_op    <= '0;
         r_waddr <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_dvd   <= dividend_i;
                  r_dsr   <= divisor_i;
                  r_op    <= op_i;
                  r_waddr <= reg_waddr_i;
               end
            end
            S_START: begin
               r_rem  <= '0;
               r_quo  <= f_abs(r_dvd, w_signed);
               r_dmag <= f_abs(r_dsr, w_signed);
               r_cnt  <= CNT_W'(XLEN);
            end
            S_CALC: begin
               r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
               r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
               r_cnt <= r_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign result_o    = r_result;
   assign ready_o     = r_ready;
   assign busy_o      = r_busy;
   assign reg_waddr_o = r_waddr_o;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a plain-arithmetic RV32M reference.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic [31:0] dividend_i, divisor_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [4:0]  reg_waddr_i;
   logic [31:0] result_o;
   logic        ready_o, busy_o;
   logic [4:0]  reg_waddr_o;

   int n_pass = 0;
   int n_tot  = 0;

   localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

   div_unit dut (
      .clk         (clk),
      .rst         (rst),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .start_i     (start_i),
      .op_i        (op_i),
      .reg_waddr_i (reg_waddr_i),
      .result_o    (result_o),
      .ready_o     (ready_o),
      .busy_o      (busy_o),
      .reg_waddr_o (reg_waddr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // RISC-V M-extension semantics, including divide-by-zero and signed overflow
   function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int  sa = a;
      int  sb = b;
      bit  ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: return (b == 0) ? a : a % b;
         OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         default: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      endcase
   endfunction

   task automatic wait_ready(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wa);
      int          n = 0;
      int          bad = 0;
      bit          got = 0;
      logic [31:0] exp = ref_div(op, a, b);
      int          lat = (b == 0) ? 2 : 35;
      while (!got && n < 80) begin
         @(posedge clk); #1;
         n++;
         if (ready_o) got = 1;
         else if (!busy_o || result_o !== 32'h0 || reg_waddr_o !== 5'h0) bad++;
         if (n == 1) begin
            // operands are latched; scrambling them must not matter
            dividend_i  = $urandom;
            divisor_i   = $urandom;
            reg_waddr_i = 5'($urandom);
         end
      end
      chk({tag, "-ready"}, 32'(got), 32'd1);
      chk({tag, "-latency"}, 32'(n), 32'(lat));
      chk({tag, "-result"}, result_o, exp);
      chk({tag, "-waddr"}, 32'(reg_waddr_o), 32'(wa));
      chk({tag, "-busy_at_ready"}, 32'(busy_o), 32'd0);
      chk({tag, "-busy_during"}, 32'(bad), 32'd0);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({tag, "-ready_1cyc"}, 32'(ready_o), 32'd0);
      chk({tag, "-result_idle"}, result_o, 32'h0);
   endtask

   task automatic go(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] wa);
      @(negedge clk);
      op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa; start_i = 1'b1;
      wait_ready(tag, op, a, b, wa);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; start_i = 1'b0; op_i = OP_DIVU; dividend_i = 0; divisor_i = 0; reg_waddr_i = 0;
      #2 rst = 1'b0;
      // first op: start held high while coming out of reset
      op_i = OP_DIVU; dividend_i = 32'd15; divisor_i = 32'd3; reg_waddr_i = 5'd12; start_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result_o, 32'h0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
      @(negedge clk) rst = 1'b1;
      wait_ready("divu15_3", OP_DIVU, 32'd15, 32'd3, 5'd12);

      go("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd1);
      go("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd2);
      go("remu_7_2",   OP_REMU, 32'd7, 32'd2, 5'd3);
      go("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd4);
      go("divu_9_0",   OP_DIVU, 32'd9, 32'd0, 5'd5);
      go("rem_9_0",    OP_REM,  32'd9, 32'd0, 5'd6);
      go("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      go("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8);

      // abort in the middle of CALC
      @(negedge clk);
      op_i = OP_DIV; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd9; start_i = 1'b1;
      repeat (10) @(posedge clk);
      #1 start_i = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_ready", 32'(ready_o), 32'd0);
      chk("abort_result", result_o, 32'h0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o) cnt++;
      end
      chk("abort_no_pulse", 32'(cnt), 32'd0);
      go("after_abort", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd10);

      // asynchronous reset during CALC
      @(negedge clk);
      op_i = OP_REMU; dividend_i = 32'd1234; divisor_i = 32'd10; reg_waddr_i = 5'd11; start_i = 1'b1;
      repeat (15) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_result", result_o, 32'h0);
      chk("arst_ready", 32'(ready_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_waddr", 32'(reg_waddr_o), 32'd0);
      start_i = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("arst_idle_busy", 32'(busy_o), 32'd0);
      go("after_arst", OP_REMU, 32'd1234, 32'd10, 5'd11);

      // random mix, small divisors often so quotients and zero-divides show up
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  rop = {1'b1, 2'($urandom)};
         logic [31:0] ra  = $urandom;
         logic [31:0] rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
         if (ra[0]) rb = -rb;
         go($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
